// File: rtl/fetch_serial.sv
// Serial Y86-64 instruction fetch: reads one byte per imem handshake, sizes the
// instruction from byte 0 and presents decoded fields with a one-cycle valid pulse.
module fetch_serial #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter bit          AUTO_START = 1'b1,
  parameter int unsigned MAX_WAIT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_in,
  input  logic        pc_load,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  output logic        busy,
  output logic        valid,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_err,
  output logic        imem_err
);

  localparam int unsigned WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [63:0]   base_q, base_d;
  logic [3:0]    k_q, k_d;
  logic [3:0]    len_q, len_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [79:0]   buf_q, buf_d;
  logic          auto_q, auto_d;

  logic [3:0]    icode_q, icode_d, ifun_q, ifun_d, rA_q, rA_d, rB_q, rB_d;
  logic [63:0]   valC_q, valC_d, valP_q, valP_d;
  logic          ierr_q, ierr_d, merr_q, merr_d;

  logic          start, finish, tmo;
  logic [63:0]   start_pc;
  logic [3:0]    len_now, fin_len;

  function automatic logic [3:0] len_of(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
      4'h7, 4'h8:             len_of = 4'd9;
      4'h3, 4'h4, 4'h5:       len_of = 4'd10;
      default:                len_of = 4'd1;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    k_d      = k_q;
    len_d    = len_q;
    wait_d   = wait_q;
    buf_d    = buf_q;
    auto_d   = 1'b0;
    icode_d  = icode_q;
    ifun_d   = ifun_q;
    rA_d     = rA_q;
    rB_d     = rB_q;
    valC_d   = valC_q;
    valP_d   = valP_q;
    ierr_d   = ierr_q;
    merr_d   = merr_q;
    start    = 1'b0;
    start_pc = pc_in;
    finish   = 1'b0;
    tmo      = 1'b0;
    len_now  = len_q;
    fin_len  = len_q;

    case (state_q)
      S_IDLE: begin
        if (pc_load) begin
          start = 1'b1;
        end else if (auto_q) begin
          start    = 1'b1;
          start_pc = RESET_PC;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          for (int unsigned i = 0; i < 10; i++) begin
            if (k_q == 4'(i)) buf_d[8*i +: 8] = imem_rdata;
          end
          // Byte 0 sizes the instruction in the same cycle it arrives.
          len_now = (k_q == 4'd0) ? len_of(imem_rdata[7:4]) : len_q;
          len_d   = len_now;
          k_d     = k_q + 4'd1;
          wait_d  = '0;
          if (k_d == len_now) begin
            finish  = 1'b1;
            fin_len = len_now;
          end
        end else if (wait_q == WAIT_LAST) begin
          finish  = 1'b1;
          tmo     = 1'b1;
          fin_len = k_q;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (pc_load) start = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_FETCH;
      base_d  = start_pc;
      k_d     = '0;
      len_d   = 4'd1;
      wait_d  = '0;
      buf_d   = '0;
    end

    // Decode from the buffer including the byte landing this cycle; missing bytes stay 0.
    if (finish) begin
      state_d = S_DONE;
      icode_d = buf_d[7:4];
      ifun_d  = buf_d[3:0];
      case (buf_d[7:4])
        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: begin
          rA_d = buf_d[15:12];
          rB_d = buf_d[11:8];
        end
        default: begin
          rA_d = 4'hF;
          rB_d = 4'hF;
        end
      endcase
      case (buf_d[7:4])
        4'h3, 4'h4, 4'h5: valC_d = buf_d[79:16];
        4'h7, 4'h8:       valC_d = buf_d[71:8];
        default:          valC_d = '0;
      endcase
      valP_d = base_q + 64'(fin_len);
      ierr_d = (buf_d[7:4] > 4'hB);
      merr_d = tmo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      k_q     <= '0;
      len_q   <= 4'd1;
      wait_q  <= '0;
      buf_q   <= '0;
      auto_q  <= AUTO_START;
      icode_q <= '0;
      ifun_q  <= '0;
      rA_q    <= 4'hF;
      rB_q    <= 4'hF;
      valC_q  <= '0;
      valP_q  <= '0;
      ierr_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      k_q     <= k_d;
      len_q   <= len_d;
      wait_q  <= wait_d;
      buf_q   <= buf_d;
      auto_q  <= auto_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      rA_q    <= rA_d;
      rB_q    <= rB_d;
      valC_q  <= valC_d;
      valP_q  <= valP_d;
      ierr_q  <= ierr_d;
      merr_q  <= merr_d;
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign busy      = (state_q == S_FETCH);
  assign valid     = (state_q == S_DONE);
  assign imem_addr = imem_req ? (base_q + 64'(k_q)) : '0;
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign rA        = rA_q;
  assign rB        = rB_q;
  assign valC      = valC_q;
  assign valP      = valP_q;
  assign instr_err = ierr_q;
  assign imem_err  = merr_q;

endmodule

// File: tb/tb_fetch_serial.sv
// Bench for fetch_serial: byte memory with per-address stalls, transaction-level
// fetch model feeding a per-cycle checker, plus literal pins on selected results.
module tb_fetch_serial;
  localparam int unsigned MW  = 16;
  localparam logic [63:0] RPC = 64'd0;

  logic        clk = 1'b0, reset = 1'b1, pc_load = 1'b0, imem_ack = 1'b0;
  logic [63:0] pc_in = '0;
  logic [7:0]  imem_rdata = '0;
  logic        imem_req, busy, valid, instr_err, imem_err;
  logic [63:0] imem_addr, valC, valP;
  logic [3:0]  icode, ifun, rA, rB;

  fetch_serial #(.RESET_PC(RPC), .AUTO_START(1'b1), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_load(pc_load),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .busy(busy), .valid(valid), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .instr_err(instr_err), .imem_err(imem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        ierr, merr;
  } res_t;

  logic [7:0]  mem [logic [63:0]];
  int unsigned wt  [logic [63:0]];
  res_t        exp_q[$];
  res_t        act_q[$];
  logic [63:0] addr_q[$];
  int unsigned cyc = 0;
  int unsigned checks = 0, failures = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic int unsigned wt_of(input logic [63:0] a);
    return wt.exists(a) ? wt[a] : 0;
  endfunction

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole-instruction model: length table, per-byte stalls, timeout, little-endian valC.
  task automatic model_fetch(input logic [63:0] pc, input int unsigned s);
    res_t        e;
    logic [7:0]  b [10];
    logic [7:0]  b0;
    int unsigned len, got, extra, off;
    bit          tmo, has_reg;
    b0 = rd(pc);
    case (b0[7:4])
      4'h2, 4'h6, 4'hA, 4'hB: len = 2;
      4'h7, 4'h8:             len = 9;
      4'h3, 4'h4, 4'h5:       len = 10;
      default:                len = 1;
    endcase
    got = 0; extra = 0; tmo = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      if (wt_of(pc + 64'(i)) >= MW) begin
        tmo = 1'b1;
        break;
      end
      extra += wt_of(pc + 64'(i));
      addr_q.push_back(pc + 64'(i));
      got++;
    end
    for (int i = 0; i < 10; i++) b[i] = (i < int'(got)) ? rd(pc + 64'(i)) : 8'h00;
    e.icode = b[0][7:4];
    e.ifun  = b[0][3:0];
    has_reg = (e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
    e.ra    = has_reg ? b[1][7:4] : 4'hF;
    e.rb    = has_reg ? b[1][3:0] : 4'hF;
    off     = (e.icode inside {4'h3, 4'h4, 4'h5}) ? 2 : (e.icode inside {4'h7, 4'h8}) ? 1 : 0;
    e.valc  = '0;
    if (off != 0)
      for (int j = 0; j < 8; j++) e.valc = e.valc | (64'(b[off + j]) << (8 * j));
    e.valp  = pc + 64'(tmo ? got : len);
    e.ierr  = (e.icode > 4'hB);
    e.merr  = tmo;
    e.cyc   = tmo ? (s + got + MW + 1) : (s + len + extra + 1);
    exp_q.push_back(e);
  endtask

  // Memory responder: stalls wt[addr] cycles per request, checks the address on ack.
  logic [63:0] cur_a = '0;
  int unsigned stall = 0;
  bit          have = 1'b0;
  always @(posedge clk) begin
    #2;
    if (imem_req) begin
      if (!have || imem_addr != cur_a) begin
        cur_a = imem_addr;
        stall = 0;
        have  = 1'b1;
      end
      if (stall < wt_of(cur_a)) begin
        imem_ack = 1'b0;
        stall++;
      end else begin
        imem_ack   = 1'b1;
        imem_rdata = rd(cur_a);
        have       = 1'b0;
        if (addr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL imem_addr_unexpected: got %0h required none", cur_a);
        end else begin
          chk64("imem_addr", cur_a, addr_q.pop_front());
        end
      end
    end else begin
      imem_ack = 1'b0;
      have     = 1'b0;
    end
  end

  // Per-cycle compare against the model queue.
  always @(negedge clk) begin
    if (chk_en) begin : cmp
      bit   ev;
      res_t e, a;
      ev = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
      chk64("valid", 64'(valid), 64'(ev));
      chk64("valid_busy_overlap", 64'(valid & busy), 64'd0);
      if (ev) begin
        e = exp_q.pop_front();
        if (valid) begin
          chk64("icode", 64'(icode), 64'(e.icode));
          chk64("ifun", 64'(ifun), 64'(e.ifun));
          chk64("rA", 64'(rA), 64'(e.ra));
          chk64("rB", 64'(rB), 64'(e.rb));
          chk64("valC", valC, e.valc);
          chk64("valP", valP, e.valp);
          chk64("instr_err", 64'(instr_err), 64'(e.ierr));
          chk64("imem_err", 64'(imem_err), 64'(e.merr));
          a.cyc = cyc; a.icode = icode; a.ifun = ifun; a.ra = rA; a.rb = rB;
          a.valc = valC; a.valp = valP; a.ierr = instr_err; a.merr = imem_err;
          act_q.push_back(a);
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic load(input logic [63:0] pc, output int unsigned s);
    @(negedge clk);
    pc_in   = pc;
    pc_load = 1'b1;
    s       = cyc;
    model_fetch(pc, s);
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk64("drain_bound", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic get_act(output res_t a, output bit ok);
    ok = (act_q.size() != 0);
    if (ok) a = act_q.pop_front();
    else begin
      checks++; failures++;
      $display("FAIL result_missing: got none required one");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int unsigned s, s2;
    res_t a;
    bit ok;
    mem[0]   = 8'h10;
    mem[2]   = 8'h10;
    mem[4]   = 8'h30; mem[5] = 8'hF3; mem[6] = 8'h0A;
    mem[36]  = 8'h73; mem[37] = 8'h32; wt[39] = 2;
    mem[100] = 8'hC0;
    mem[109] = 8'h90;
    mem[111] = 8'hA0; mem[112] = 8'h2F; wt[112] = 1000;
    mem[200] = 8'h30; mem[201] = 8'hF4; mem[202] = 8'h55;

    repeat (2) @(negedge clk);
    chk64("rst_req", 64'(imem_req), 64'd0);
    chk64("rst_valid", 64'(valid), 64'd0);
    chk64("rst_busy", 64'(busy), 64'd0);
    chk64("rst_rA", 64'(rA), 64'hF);
    chk64("rst_rB", 64'(rB), 64'hF);
    chk64("rst_icode", 64'(icode), 64'd0);
    chk64("rst_valC", valC, 64'd0);
    chk64("rst_valP", valP, 64'd0);
    chk64("rst_errs", 64'({instr_err, imem_err}), 64'd0);

    reset = 1'b0;
    s = cyc;
    model_fetch(RPC, s);
    chk_en = 1'b1;
    drain();
    get_act(a, ok);
    if (ok) begin
      chk64("auto_lat", 64'(a.cyc - s), 64'd2);
      chk64("auto_valP", a.valp, 64'd1);
    end

    load(64'd2, s); drain();
    get_act(a, ok);
    if (ok) begin
      chk64("nop_lat", 64'(a.cyc - s), 64'd2);
      chk64("nop_icode", 64'(a.icode), 64'd1);
      chk64("nop_rArB", 64'({a.ra, a.rb}), 64'hFF);
      chk64("nop_valC", a.valc, 64'd0);
      chk64("nop_valP", a.valp, 64'd3);
    end
    repeat (3) @(negedge clk);
    chk64("hold_icode", 64'(icode), 64'd1);
    chk64("hold_valP", valP, 64'd3);

    load(64'd4, s); drain();
    get_act(a, ok);
    if (ok) begin
      chk64("irmov_lat", 64'(a.cyc - s), 64'd11);
      chk64("irmov_rArB", 64'({a.ra, a.rb}), 64'hF3);
      chk64("irmov_valC", a.valc, 64'd10);
      chk64("irmov_valP", a.valp, 64'd14);
    end

    load(64'd36, s); drain();
    get_act(a, ok);
    if (ok) begin
      chk64("jxx_lat", 64'(a.cyc - s), 64'd12);
      chk64("jxx_code", 64'({a.icode, a.ifun}), 64'h73);
      chk64("jxx_valC", a.valc, 64'd50);
      chk64("jxx_valP", a.valp, 64'd45);
      chk64("jxx_merr", 64'(a.merr), 64'd0);
    end

    load(64'd100, s);
    load(64'd109, s2);
    chk64("b2b_load_in_done", 64'(s2 - s), 64'd2);
    drain();
    get_act(a, ok);
    if (ok) begin
      chk64("bad_lat", 64'(a.cyc - s), 64'd2);
      chk64("bad_ierr", 64'(a.ierr), 64'd1);
      chk64("bad_valP", a.valp, 64'd101);
    end
    get_act(a, ok);
    if (ok) begin
      chk64("ret_lat", 64'(a.cyc - s2), 64'd2);
      chk64("ret_icode", 64'(a.icode), 64'd9);
      chk64("ret_valP", a.valp, 64'd110);
    end

    load(64'd111, s); drain();
    get_act(a, ok);
    if (ok) begin
      chk64("tmo_lat", 64'(a.cyc - s), 64'd18);
      chk64("tmo_merr", 64'(a.merr), 64'd1);
      chk64("tmo_icode", 64'(a.icode), 64'hA);
      chk64("tmo_valP", a.valp, 64'd112);
    end

    load(64'd200, s);
    repeat (4) @(negedge clk);
    chk64("k4_addr", imem_addr, 64'd204);
    reset = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk64("midrst_req", 64'(imem_req), 64'd0);
    chk64("midrst_valid", 64'(valid), 64'd0);
    chk64("midrst_busy", 64'(busy), 64'd0);
    s = cyc;
    model_fetch(RPC, s);
    @(negedge clk);
    chk64("restart_req", 64'(imem_req), 64'd1);
    chk64("restart_addr", imem_addr, RPC);
    drain();
    get_act(a, ok);
    if (ok) begin
      chk64("restart_lat", 64'(a.cyc - s), 64'd2);
      chk64("restart_valP", a.valp, 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_serial.md
Name: fetch_serial

Overview:
- Fetch stage for the SEQ core. It sits directly downstream of the PC-update stage and consumes its updatedPC.
- Reads one Y86-64 instruction a byte at a time from a byte-wide instruction memory using a req/ack handshake.
- Decodes the instruction length, then assembles icode, ifun, rA, rB, valC and valP.
- Presents the result to decode/execute with a one-cycle valid pulse.

Parameters:
- RESET_PC, 64'd0: PC fetched automatically after reset when AUTO_START=1.
- AUTO_START, 1: 1 starts a fetch at RESET_PC on the first cycle after reset; 0 waits for pc_load.
- MAX_WAIT, 16: number of consecutive cycles without imem_ack on one byte before the fetch aborts with imem_err.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  64  next PC (updatedPC from the PC-update stage).
- pc_load  in  1  one-cycle pulse that starts a fetch at pc_in.
- imem_req  out  1  byte read request.
- imem_addr  out  64  byte address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  imem_rdata is valid this cycle.
- imem_rdata  in  8  instruction byte.
- busy  out  1  high in the FETCH state.
- valid  out  1  one-cycle pulse; the instruction fields below are valid.
- icode  out  4  instruction code.
- ifun  out  4  function code.
- rA  out  4  register A; 4'hF if the instruction has no register byte.
- rB  out  4  register B; 4'hF if the instruction has no register byte.
- valC  out  64  constant word; 0 if the instruction has none.
- valP  out  64  PC + instruction length.
- instr_err  out  1  icode > 4'hB; sampled with valid.
- imem_err  out  1  MAX_WAIT timeout; sampled with valid.

Behaviour:
- Reset (synchronous, edge with reset=1):
  - State goes to IDLE; byte counter and wait counter clear.
  - All outputs are 0 except rA=rB=4'hF.
  - Reset during FETCH abandons the access; imem_req is 0 after that edge.
- States: IDLE, FETCH, DONE.
  - IDLE -> FETCH: on pc_load, or on the first cycle after reset when AUTO_START=1.
  - On entering FETCH, base PC latches pc_in (or RESET_PC), the byte index k is set to 0, and the expected length is set to 1.
- FETCH:
  - imem_req=1 and imem_addr = base + k.
  - On a cycle with imem_ack, imem_rdata is captured as byte k, k increments, and the wait counter clears.
  - A new request (next address) follows on the next cycle with no idle gap. A zero-wait memory therefore delivers one byte per cycle.
- Length is determined from byte 0 (icode = high nibble, ifun = low nibble):
  - 0, 1, 9 -> 1 byte.
  - 2, 6, A, B -> 2 bytes.
  - 7, 8 -> 9 bytes.
  - 3, 4, 5 -> 10 bytes.
  - Anything else -> 1 byte with instr_err=1.
- Field assembly:
  - Byte 1 gives rA = high nibble and rB = low nibble, for icodes 2, 3, 4, 5, 6, A, B.
  - valC is little-endian: bytes 2..9 for icodes 3, 4, 5; bytes 1..8 for icodes 7, 8.
- FETCH -> DONE: on the edge at which the last byte is acked.
- DONE:
  - valid=1 for exactly one cycle.
  - valP = base + length, computed mod 2^64 (wrap-around allowed, no error).
  - Next state is IDLE, or FETCH if pc_load=1 in this cycle. Back-to-back fetch: valid and busy never overlap.
- Field retention: output fields hold their values until the next DONE; they are not cleared in IDLE.
- pc_load while in FETCH is ignored; the current fetch completes.
- Timeout:
  - In FETCH, the wait counter increments on each cycle with imem_req=1 and imem_ack=0.
  - When it reaches MAX_WAIT, the block goes to DONE with imem_err=1 and valP = base + k. Already-captured fields are reported; uncaptured bytes read as 0.
- imem_ack outside FETCH is ignored.
- Latency: with zero-wait memory, an instruction of L bytes gives valid exactly L+1 cycles after the pc_load cycle. Each wait cycle adds one cycle.

Test Plan:
- Zero-wait memory, pc_load with pc_in=2, byte 8'h10 (nop) -> 1 request at address 2; valid 2 cycles after pc_load; icode=1, rA=rB=F, valC=0, valP=3.
- pc_in=4, bytes 30 F3 0A 00 00 00 00 00 00 00 (irmovq) -> requests at addresses 4..13; valid 11 cycles after pc_load; rA=F, rB=3, valC=10, valP=14.
- pc_in=36, jXX bytes 73 32 00 00 00 00 00 00 00, with 2 wait cycles inserted on byte 3 -> valid 12 cycles after pc_load; icode=7, ifun=3, valC=50, valP=45, imem_err=0.
- pc_in=100, byte 8'hC0 -> valid 2 cycles after pc_load; instr_err=1, valP=101. Back-to-back pc_load in the DONE cycle with pc_in=109 and byte 8'h90 (ret) -> FETCH starts immediately, valP=110.
- MAX_WAIT=16, ack withheld on byte 1 of pushq at pc 111 -> after 16 wait cycles, valid with imem_err=1, icode=A, valP=112.
- reset asserted mid-fetch of an irmovq at k=4 -> next cycle imem_req=0, valid=0, state IDLE. With AUTO_START=1, a fetch at RESET_PC begins the following cycle.
